ace_snap_dump: RTL

Snapshot dumper for the Jupiter Ace core. It is the reverse of the snapshot loader path. On a start request it holds the CPU and reads the RAM image from 0x2000 up to END_ADDR. In the 0x2100–0x217F window it replaces memory contents with the captured CPU register set. The resulting byte stream is compressed with the .ace run-length scheme (ED count value, terminated by ED 00) and presented to the host/HPS side through a valid/ready byte stream.

---
 rtl/ace_snap_dump.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ace_snap_dump.sv
// ace_snap_dump
// Dumps the Jupiter Ace RAM image (0x2000..END_ADDR) as an .ace run-length
// compressed byte stream while holding the CPU. Reads that fall in the
// 0x2100..0x217F page return the CPU register set captured at start instead of memory.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start               one-cycle dump request (ignored while busy)
//   reg_snap[211:0]     CPU register vector (T80 DIR layout)
//   cpu_hold, busy      high for the whole dump, fall the cycle after done
//   done                one-cycle pulse after the ED 00 terminator is accepted
//   mem_addr, mem_rd    RAM read port; mem_data valid the cycle after mem_rd
//   mem_data[7:0]       RAM read data
//   out_data/valid/ready  byte stream to host
//
// state      | meaning
// IDLE       | waiting for start
// LATCH      | register snapshot held, CPU held
// FETCH      | issue memory read or pick register page byte
// WAIT       | capture mem_data
// ACCUM      | merge byte into run, or request a flush first
// EMIT_ED    | ED marker of a compressed record
// EMIT_CNT   | run length of a compressed record
// EMIT_VAL   | run value of a compressed record
// EMIT_LIT   | run emitted literally, one byte per accept
// FLUSH_END  | last address absorbed, flush final run
// TERM0      | terminator ED
// TERM1      | terminator 00
// DONE       | done pulse
module ace_snap_dump #(
   parameter logic [15:0] END_ADDR = 16'h3FFF,
   parameter int unsigned MAX_RUN  = 240
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [211:0] reg_snap,
   output logic         cpu_hold,
   output logic         busy,
   output logic         done,
   output logic [15:0]  mem_addr,
   output logic         mem_rd,
   input  logic [7:0]   mem_data,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [3:0] {
      S_IDLE, S_LATCH, S_FETCH, S_WAIT, S_ACCUM, S_EMIT_ED, S_EMIT_CNT,
      S_EMIT_VAL, S_EMIT_LIT, S_FLUSH_END, S_TERM0, S_TERM1, S_DONE
   } state_t;

   localparam logic [7:0] MAX_RUN_B = 8'(MAX_RUN);

   state_t         state_q, state_d;
   logic [15:0]    addr_q, addr_d;
   logic [7:0]     byte_q, byte_d;
   logic [7:0]     run_val_q, run_val_d;
   logic [7:0]     run_len_q, run_len_d;
   logic           fin_q, fin_d;
   logic [211:0]   snap_q, snap_d;

   logic           last;
   logic           in_page;
   logic           need_ed;
   state_t         flush_state;
   state_t         ret_state;

   function automatic logic [7:0] page_byte(input logic [211:0] r, input logic [6:0] off);
      logic [7:0] b;
      case (off)
         7'h00: b = r[15:8];
         7'h01: b = r[7:0];
         7'h04: b = r[87:80];
         7'h05: b = r[95:88];
         7'h08: b = r[103:96];
         7'h09: b = r[111:104];
         7'h0C: b = r[119:112];
         7'h0D: b = r[127:120];
         7'h10: b = r[135:128];
         7'h11: b = r[143:136];
         7'h14: b = r[199:192];
         7'h15: b = r[207:200];
         7'h18: b = r[55:48];
         7'h19: b = r[63:56];
         7'h1C: b = r[71:64];
         7'h1D: b = r[79:72];
         7'h20: b = r[31:24];
         7'h21: b = r[23:16];
         7'h24: b = r[151:144];
         7'h25: b = r[159:152];
         7'h28: b = r[167:160];
         7'h29: b = r[175:168];
         7'h2C: b = r[183:176];
         7'h2D: b = r[191:184];
         7'h30: b = {6'b0, r[209:208]};
         7'h34: b = {7'b0, r[210]};
         7'h38: b = {7'b0, r[211]};
         7'h3C: b = r[39:32];
         7'h40: b = r[47:40];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= 16'h2000;
         byte_q    <= 8'h00;
         run_val_q <= 8'h00;
         run_len_q <= 8'h00;
         fin_q     <= 1'b0;
         snap_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         byte_q    <= byte_d;
         run_val_q <= run_val_d;
         run_len_q <= run_len_d;
         fin_q     <= fin_d;
         snap_q    <= snap_d;
      end
   end

   assign last        = (addr_q == END_ADDR);
   assign in_page     = (addr_q[15:7] == 9'h042);
   // A lone ED byte must be escaped, otherwise the loader would read it as a marker.
   assign need_ed     = (run_len_q >= 8'd3) || (run_val_q == 8'hED);
   assign flush_state = need_ed ? S_EMIT_ED : S_EMIT_LIT;
   // After a flush, either go back to absorb the pending byte or finish.
   assign ret_state   = fin_q ? S_TERM0 : S_ACCUM;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      byte_d    = byte_q;
      run_val_d = run_val_q;
      run_len_d = run_len_q;
      fin_d     = fin_q;
      snap_d    = snap_q;
      mem_rd    = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d    = reg_snap;
               addr_d    = 16'h2000;
               run_len_d = 8'h00;
               fin_d     = 1'b0;
               state_d   = S_LATCH;
            end
         end
         S_LATCH: state_d = S_FETCH;
         S_FETCH: begin
            if (in_page) begin
               byte_d  = page_byte(snap_q, addr_q[6:0]);
               state_d = S_ACCUM;
            end else begin
               mem_rd  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            byte_d  = mem_data;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            if ((run_len_q == 8'h00) ||
                ((byte_q == run_val_q) && (run_len_q < MAX_RUN_B))) begin
               run_val_d = byte_q;
               run_len_d = run_len_q + 8'd1;
               if (last) begin
                  fin_d   = 1'b1;
                  state_d = S_FLUSH_END;
               end else begin
                  addr_d  = addr_q + 16'd1;
                  state_d = S_FETCH;
               end
            end else begin
               state_d = flush_state;
            end
         end
         S_FLUSH_END: state_d = flush_state;
         S_EMIT_ED: begin
            out_valid = 1'b1;
            out_data  = 8'hED;
            if (out_ready) state_d = S_EMIT_CNT;
         end
         S_EMIT_CNT: begin
            out_valid = 1'b1;
            out_data  = run_len_q;
            if (out_ready) state_d = S_EMIT_VAL;
         end
         S_EMIT_VAL: begin
            out_valid = 1'b1;
            out_data  = run_val_q;
            if (out_ready) begin
               run_len_d = 8'h00;
               state_d   = ret_state;
            end
         end
         S_EMIT_LIT: begin
            out_valid = 1'b1;
            out_data  = run_val_q;
            if (out_ready) begin
               run_len_d = run_len_q - 8'd1;
               if (run_len_q == 8'd1) state_d = ret_state;
            end
         end
         S_TERM0: begin
            out_valid = 1'b1;
            out_data  = 8'hED;
            if (out_ready) state_d = S_TERM1;
         end
         S_TERM1: begin
            out_valid = 1'b1;
            out_data  = 8'h00;
            if (out_ready) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign cpu_hold = busy;
   assign mem_addr = addr_q;

endmodule
